matrix_transpose_buf: RTL and testbench

//   Parametrised row-in / column-out transpose buffer for the matrix_cal pipeline.

---
 rtl/matrix_transpose_buf.sv | 125 ++++++++++++
 tb/tb_matrix_transpose_buf.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_transpose_buf.sv
// Row-in / column-out N x N transpose buffer; optional ping-pong banking via TRANSPOSE_PINGPONG_EN.
// First column valid the cycle after the last row; single bank serialises blocks, two banks overlap them.
module matrix_transpose_buf #(
    parameter int N  = 16,
    parameter int DW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            src_row_vld,
    output logic            src_row_rdy,
    input  logic [N*DW-1:0] src_row_data,
    output logic            dst_col_vld,
    input  logic            dst_col_rdy,
    output logic [N*DW-1:0] dst_col_data,
    output logic            blk_done
);

`ifdef TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    bank_state_t   bank_st  [NB];
    bank_state_t   bank_nxt [NB];
    logic [DW-1:0] mem      [NB][N][N];

    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          wr_bank;
    logic          rd_bank;
    logic          wr_fire;
    logic          rd_fire;
    logic          wr_last;
    logic          rd_last;

    assign src_row_rdy = !rst && (bank_st[wr_bank] != BANK_FULL);
    assign dst_col_vld = (bank_st[rd_bank] == BANK_FULL);
    assign wr_fire     = src_row_vld && src_row_rdy;
    assign rd_fire     = dst_col_vld && dst_col_rdy;
    assign wr_last     = (wr_cnt == LAST);
    assign rd_last     = (rd_cnt == LAST);

    // Fill and drain touch different banks when both complete in one cycle, so both apply.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bank_nxt[b] = bank_st[b];
            if (wr_fire && wr_last && (wr_bank == 1'(b)))
                bank_nxt[b] = BANK_FULL;
            if (rd_fire && rd_last && (rd_bank == 1'(b)))
                bank_nxt[b] = BANK_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++)
                bank_st[b] <= BANK_EMPTY;
        end else begin
            for (int b = 0; b < NB; b++)
                bank_st[b] <= bank_nxt[b];
        end
    end

`ifdef TRANSPOSE_PINGPONG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (wr_fire && wr_last)
                wr_bank <= ~wr_bank;
            if (rd_fire && rd_last)
                rd_bank <= ~rd_bank;
        end
    end
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

    // Explicit wrap keeps non-power-of-two N inside the array bounds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            blk_done <= 1'b0;
        end else begin
            if (wr_fire)
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
            if (rd_fire)
                rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
            blk_done <= rd_fire && rd_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        mem[b][r][c] <= '0;
        end else if (wr_fire) begin
            for (int c = 0; c < N; c++)
                mem[wr_bank][wr_cnt][c] <= src_row_data[c*DW +: DW];
        end
    end

    // Column is a pure mux of stored rows, so it cannot move while held under backpressure.
    always_comb begin
        dst_col_data = '0;
        if (dst_col_vld) begin
            for (int r = 0; r < N; r++)
                dst_col_data[r*DW +: DW] = mem[rd_bank][r][rd_cnt];
        end
    end

endmodule

// File: tb/tb_matrix_transpose_buf.sv
// Randomised and directed bench for matrix_transpose_buf (N=4, DW=8) with a block-level queue model.
module tb_matrix_transpose_buf;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int W  = N * DW;
`ifdef TRANSPOSE_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         src_row_vld = 1'b0;
    logic         src_row_rdy;
    logic [W-1:0] src_row_data = '0;
    logic         dst_col_vld;
    logic         dst_col_rdy = 1'b0;
    logic [W-1:0] dst_col_data;
    logic         blk_done;

    always #5 clk = ~clk;

    matrix_transpose_buf #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .src_row_vld(src_row_vld), .src_row_rdy(src_row_rdy), .src_row_data(src_row_data),
        .dst_col_vld(dst_col_vld), .dst_col_rdy(dst_col_rdy), .dst_col_data(dst_col_data),
        .blk_done(blk_done)
    );

    int checks = 0;
    int errors = 0;

    // Block-level model: completed blocks waiting to drain, and their columns in order.
    logic [W-1:0]  exp_cols[$];
    logic [DW-1:0] cur_rows[N][N];
    int            full_blocks, wr_rows, rd_cols, blocks_read;
    bit            done_pending;

    logic         o_rdy, o_vld, o_done, e_rdy, e_vld, e_done;
    logic [W-1:0] o_data, e_data;

    function automatic logic [W-1:0] pat_row(int off, int r);
        logic [W-1:0] v;
        for (int k = 0; k < N; k++)
            v[k*DW +: DW] = DW'(off + 16*r + k);
        return v;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] v;
        for (int k = 0; k < N; k++)
            v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic model_clear();
        exp_cols.delete();
        full_blocks  = 0;
        wr_rows      = 0;
        rd_cols      = 0;
        done_pending = 0;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        src_row_vld  = v;
        src_row_data = d;
        dst_col_rdy  = r;
        @(negedge clk);
        o_rdy  = src_row_rdy;
        o_vld  = dst_col_vld;
        o_data = dst_col_data;
        o_done = blk_done;
        e_rdy  = !rst && (full_blocks < CAP);
        e_vld  = (full_blocks > 0);
        e_data = e_vld ? exp_cols[0] : '0;
        e_done = done_pending;
    endtask

    task automatic commit();
        logic         wf, rf;
        logic [W-1:0] col;
        wf = src_row_vld && e_rdy;
        rf = dst_col_rdy && e_vld;
        done_pending = 0;
        if (rf) begin
            void'(exp_cols.pop_front());
            rd_cols++;
            if (rd_cols == N) begin
                rd_cols = 0;
                full_blocks--;
                blocks_read++;
                done_pending = 1;
            end
        end
        if (wf) begin
            for (int k = 0; k < N; k++)
                cur_rows[wr_rows][k] = src_row_data[k*DW +: DW];
            wr_rows++;
            if (wr_rows == N) begin
                for (int c = 0; c < N; c++) begin
                    for (int r = 0; r < N; r++)
                        col[r*DW +: DW] = cur_rows[r][c];
                    exp_cols.push_back(col);
                end
                wr_rows = 0;
                full_blocks++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && full_blocks > 0; i++) begin
            drive(1'b0, '0, 1'b1);
            commit();
        end
    endtask

    task automatic test_reset();
        model_clear();
        #1 rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b0);
            checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", o_rdy); end
            checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", o_vld); end
            checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", o_data); end
            checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_rdy: got %b want 1", o_rdy); end
        commit();
    endtask

    task automatic test_single_block();
        logic [W-1:0] col;
        for (int i = 0; i < N; i++) begin
            drive(1'b1, pat_row(0, i), 1'b1);
            checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL single_wr_rdy: got %b want 1", o_rdy); end
            checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL single_early_vld: got %b want 0", o_vld); end
            commit();
        end
        for (int c = 0; c < N; c++) begin
            drive(1'b0, rand_row(), 1'b1);
            for (int r = 0; r < N; r++)
                col[r*DW +: DW] = DW'(16*r + c);
            checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL single_vld c%0d: got %b want 1", c, o_vld); end
            checks++; if (o_data !== col) begin errors++; $display("FAIL single_col c%0d: got %h want %h", c, o_data, col); end
            checks++; if (o_rdy !== e_rdy) begin errors++; $display("FAIL single_rd_rdy c%0d: got %b want %b", c, o_rdy, e_rdy); end
            if (c == 0) begin
                checks++; if (o_data !== 32'h30201000) begin errors++; $display("FAIL single_col0_const: got %h want 30201000", o_data); end
            end
            if (c == N-1) begin
                checks++; if (o_data !== 32'h33231303) begin errors++; $display("FAIL single_col3_const: got %h want 33231303", o_data); end
            end
            checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL single_done_early c%0d: got %b want 0", c, o_done); end
            commit();
        end
        drive(1'b0, '0, 1'b1);
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", o_done); end
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL single_vld_after: got %b want 0", o_vld); end
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy_after: got %b want 1", o_rdy); end
        commit();
        drive(1'b0, '0, 1'b1);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL single_done_once: got %b want 0", o_done); end
        commit();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) begin
            drive(1'b1, pat_row(0, i), 1'b0);
            commit();
        end
        drive(1'b0, '0, 1'b1);
        checks++; if (o_data !== 32'h30201000) begin errors++; $display("FAIL bp_col0: got %h want 30201000", o_data); end
        commit();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, rand_row(), 1'b0);
            checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL bp_vld cyc%0d: got %b want 1", i, o_vld); end
            checks++; if (o_data !== 32'h31211101) begin errors++; $display("FAIL bp_hold cyc%0d: got %h want 31211101", i, o_data); end
`ifndef TRANSPOSE_PINGPONG_EN
            checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL bp_src_rdy cyc%0d: got %b want 0", i, o_rdy); end
`endif
            commit();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, first = -1, last = -1;
        bit gap = 0;
        for (int cyc = 0; cyc < 60 && got < 3*N; cyc++) begin
            drive(sent < 3*N, pat_row(64*(sent/N), sent%N), 1'b1);
            checks++; if (o_rdy !== e_rdy) begin errors++; $display("FAIL b2b_rdy cyc%0d: got %b want %b", cyc, o_rdy, e_rdy); end
            checks++; if (o_vld !== e_vld) begin errors++; $display("FAIL b2b_vld cyc%0d: got %b want %b", cyc, o_vld, e_vld); end
            if (e_vld) begin
                checks++; if (o_data !== e_data) begin errors++; $display("FAIL b2b_data cyc%0d: got %h want %h", cyc, o_data, e_data); end
            end
            checks++; if (o_done !== e_done) begin errors++; $display("FAIL b2b_done cyc%0d: got %b want %b", cyc, o_done, e_done); end
            if (o_vld) begin
                if (first < 0) first = cyc;
                last = cyc;
            end else if (first >= 0) begin
                gap = 1;
            end
            if (src_row_vld && e_rdy) sent++;
            if (e_vld) got++;
            commit();
        end
        checks++; if (got != 3*N) begin errors++; $display("FAIL b2b_count: got %0d columns want %0d", got, 3*N); end
`ifdef TRANSPOSE_PINGPONG_EN
        checks++; if (gap) begin errors++; $display("FAIL b2b_gap: got vld gap want none"); end
        checks++; if (last != 4*N-1) begin errors++; $display("FAIL b2b_last_cycle: got %0d want %0d", last, 4*N-1); end
`endif
        drain();
    endtask

    task automatic test_simultaneous();
        int s = 0;
        for (int i = 0; i < N; i++) begin
            drive(1'b1, pat_row(0, i), 1'b0);
            commit();
        end
        for (int i = 0; i < 40 && s < N; i++) begin
            drive(1'b1, pat_row(64, s), 1'b1);
            if (e_rdy) s++;
            commit();
        end
        drive(1'b0, '0, 1'b1);
        checks++; if (o_vld !== e_vld) begin errors++; $display("FAIL simul_vld_model: got %b want %b", o_vld, e_vld); end
        if (e_vld) begin
            checks++; if (o_data !== e_data) begin errors++; $display("FAIL simul_data_model: got %h want %h", o_data, e_data); end
        end
`ifdef TRANSPOSE_PINGPONG_EN
        checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL simul_vld: got %b want 1", o_vld); end
        checks++; if (o_data !== 32'h70605040) begin errors++; $display("FAIL simul_col0: got %h want 70605040", o_data); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL simul_done: got %b want 1", o_done); end
`endif
        commit();
        drain();
    endtask

    task automatic test_reset_mid();
        int got = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, pat_row(0, i), 1'b1);
            commit();
        end
        #2 rst = 1'b1;
        model_clear();
        drive(1'b0, '0, 1'b1);
        checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b want 0", o_rdy); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, rand_row(), 1'b1);
            checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL midrst_no_col cyc%0d: got %b want 0", i, o_vld); end
            commit();
        end
        for (int i = 0; i < N; i++) begin
            drive(1'b1, pat_row(64, i), 1'b1);
            commit();
        end
        for (int i = 0; i < 20 && got < N; i++) begin
            drive(1'b0, '0, 1'b1);
            checks++; if (o_vld !== e_vld) begin errors++; $display("FAIL midrst_vld cyc%0d: got %b want %b", i, o_vld, e_vld); end
            if (e_vld) begin
                checks++; if (o_data !== e_data) begin errors++; $display("FAIL midrst_data cyc%0d: got %h want %h", i, o_data, e_data); end
                got++;
            end
            commit();
        end
        checks++; if (got != N) begin errors++; $display("FAIL midrst_count: got %0d want %0d", got, N); end
        drain();
    endtask

    task automatic test_random();
        int src_gap = 0, dst_gap = 0, target, cyc;
        logic wf, rf;
        target = blocks_read + 200;
        for (cyc = 0; cyc < 40000 && blocks_read < target; cyc++) begin
            drive(src_gap == 0, rand_row(), dst_gap == 0);
            checks++; if (o_rdy !== e_rdy) begin errors++; $display("FAIL rand_rdy cyc%0d: got %b want %b", cyc, o_rdy, e_rdy); end
            checks++; if (o_vld !== e_vld) begin errors++; $display("FAIL rand_vld cyc%0d: got %b want %b", cyc, o_vld, e_vld); end
            if (e_vld) begin
                checks++; if (o_data !== e_data) begin errors++; $display("FAIL rand_data cyc%0d: got %h want %h", cyc, o_data, e_data); end
            end
            checks++; if (o_done !== e_done) begin errors++; $display("FAIL rand_done cyc%0d: got %b want %b", cyc, o_done, e_done); end
            wf = src_row_vld && e_rdy;
            rf = dst_col_rdy && e_vld;
            if (src_gap > 0) src_gap--;
            else if (wf && $urandom_range(0, 1) == 1) src_gap = $urandom_range(1, 10);
            if (dst_gap > 0) dst_gap--;
            else if ((rf || !e_vld) && $urandom_range(0, 1) == 1) dst_gap = $urandom_range(1, 10);
            commit();
        end
        checks++; if (blocks_read < target) begin errors++; $display("FAIL rand_timeout: got %0d blocks want %0d", blocks_read, target); end
    endtask

    initial begin
        blocks_read = 0;
        test_reset();
        test_single_block();
        test_backpressure();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
